// File: rtl/tv_sequencer.sv
// tv_sequencer: walks every {a,b,c} combination into the sillyfunction block,
// waits a programmable settle time, samples y against the EXPECTED truth table
// and reports error count, first failing vector and a pass/fail verdict.
//
// Optional build macro TV_STOP_ON_ERR_EN: the first mismatch ends the run and
// a,b,c keep presenting the failing vector for debug.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | vector driven, counting down the settle delay
// CHECK  | sampling y and comparing against EXPECTED[idx]
// DONE   | run finished, verdict held until the next start
module tv_sequencer #(
  parameter int                  NIN      = 3,
  parameter logic [2**NIN-1:0]   EXPECTED = 8'h31,
  parameter int                  SETTLE   = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic           a,
  output logic           b,
  output logic           c,
  input  logic           y,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   err_count,
  output logic           fail_valid,
  output logic [NIN-1:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE_S, CHECK, DONE} state_t;

  localparam logic [NIN-1:0] IDX_LAST = {NIN{1'b1}};
  localparam logic [NIN-1:0] IDX_ONE  = NIN'(1);
  localparam logic [3:0]     CNT_INIT = 4'(SETTLE - 1);

  state_t         state_q;
  logic [NIN-1:0] idx_q;
  logic [3:0]     cnt_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic [NIN:0]   err_q;
  logic           fvalid_q;
  logic [NIN-1:0] ffidx_q;

  logic           mismatch_d;
  logic [NIN:0]   err_d;

  // Compare the sampled y with the expected bit for the current vector; the
  // incremented count feeds the verdict so a last-vector miss is included.
  always_comb begin
    mismatch_d = y ^ EXPECTED[idx_q];
    err_d      = err_q + {{NIN{1'b0}}, mismatch_d};
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      ffidx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= SETTLE_S;
            idx_q    <= '0;
            cnt_q    <= CNT_INIT;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            ffidx_q  <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        SETTLE_S: begin
          if (cnt_q == 4'd0) state_q <= CHECK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        CHECK: begin
          if (mismatch_d) begin
            err_q <= err_d;
            if (!fvalid_q) begin
              fvalid_q <= 1'b1;
              ffidx_q  <= idx_q;
            end
          end
`ifdef TV_STOP_ON_ERR_EN
          if (mismatch_d || idx_q == IDX_LAST) begin
`else
          if (idx_q == IDX_LAST) begin
`endif
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q   <= idx_q + IDX_ONE;
            cnt_q   <= CNT_INIT;
            state_q <= SETTLE_S;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a              = idx_q[NIN-1];
  assign b              = idx_q[NIN-2];
  assign c              = idx_q[NIN-3];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fvalid_q;
  assign first_fail_idx = ffidx_q;

endmodule

// File: tb/tb_tv_sequencer.sv
// Bench for tv_sequencer: a behavioural sillyfunction model with selectable
// faults drives y; a second instance with SETTLE=3 sees a 2-cycle-delayed y.
module tb_tv_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, start1;
  logic       a, b, c, y, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] ffi;
  logic       a1, b1, c1, y1, busy1, done1, pass1, fail_valid1;
  logic [3:0] err_count1;
  logic [2:0] ffi1;
  logic [2:0] d1, d2;
  int         mode;
  int         checks = 0;
  int         errors = 0;

  tv_sequencer u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .c(c), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_idx(ffi)
  );

  tv_sequencer #(.SETTLE(3)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .c(c1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .first_fail_idx(ffi1)
  );

  function automatic logic golden(input logic ga, input logic gb, input logic gc);
    return (~gb & ~gc) | (ga & ~gb);
  endfunction

  // Fault modes: 0 good, 1 stuck-0, 2 inverted, 3 stuck-1, 5 wrong only at 111
  always_comb begin
    y = golden(a, b, c);
    case (mode)
      1: y = 1'b0;
      2: y = ~golden(a, b, c);
      3: y = 1'b1;
      5: y = golden(a, b, c) ^ (a & b & c);
      default: y = golden(a, b, c);
    endcase
  end

  // Two-cycle pipeline delay between u1's vector and its y.
  always @(posedge clk) begin
    d1 <= {a1, b1, c1};
    d2 <= d1;
  end
  assign y1 = golden(d2[2], d2[1], d2[0]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic run0(input int exp_cyc, input int exp_fin, input int poke_at);
    int cyc;
    int bad;
    bit seen;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_err_clear", err_count, 0);
    chk("accept_pass_clear", pass, 0);
    chk("accept_fv_clear", fail_valid, 0);
    chk("accept_abc", {a, b, c}, 0);
    cyc  = 0;
    bad  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (cyc == poke_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
      else if ({a, b, c} !== 3'(cyc / 2)) bad++;
    end
    chk("done_latency", cyc, exp_cyc);
    chk("abc_stepping", bad, 0);
    chk("final_idx", {a, b, c}, exp_fin);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  typedef struct {
    int mode;
    int pass;
    int err;
    int fv;
    int ffi;
    int cyc;
    int fin;
    int poke;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc;
    int seen;
    tbl[0] = '{0, 1, 0, 0, 0, 16, 7, 5};
`ifdef TV_STOP_ON_ERR_EN
    tbl[1] = '{1, 0, 1, 1, 0, 2, 0, -1};
    tbl[2] = '{3, 0, 1, 1, 1, 4, 1, -1};
    tbl[3] = '{5, 0, 1, 1, 7, 16, 7, -1};
    tbl[4] = '{2, 0, 1, 1, 0, 2, 0, -1};
`else
    tbl[1] = '{1, 0, 3, 1, 0, 16, 7, -1};
    tbl[2] = '{3, 0, 5, 1, 1, 16, 7, -1};
    tbl[3] = '{5, 0, 1, 1, 7, 16, 7, -1};
    tbl[4] = '{2, 0, 8, 1, 0, 16, 7, -1};
`endif
    tbl[5] = '{0, 1, 0, 0, 0, 16, 7, -1};

    reset_n = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    mode    = 0;
    repeat (3) @(negedge clk);
    chk("rst_abc", {a, b, c}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_ffi", ffi, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      run0(tbl[i].cyc, tbl[i].fin, tbl[i].poke);
      chk("verdict_pass", pass, tbl[i].pass);
      chk("verdict_err", err_count, tbl[i].err);
      chk("verdict_fv", fail_valid, tbl[i].fv);
      chk("verdict_ffi", ffi, tbl[i].ffi);
    end

    // Reset mid-run: outputs return to reset values and no done pulse follows.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_abc", {a, b, c}, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_idle_busy", busy, 0);
    run0(16, 7, -1);
    chk("postrst_pass", pass, 1);
    chk("postrst_err", err_count, 0);

    // Slow instance: settle 3, y lags the vector by two cycles.
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("slow_done_latency", cyc, 32);
    chk("slow_pass", pass1, 1);
    chk("slow_err", err_count1, 0);
    chk("slow_fv", fail_valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tv_sequencer.md
Name: tv_sequencer

Overview:
- Synthesizable stimulus/check stage that sits directly upstream and downstream of the combinational sillyfunction block.
- It drives the block's a, b and c inputs through every input combination. After a programmable settle delay it samples y and compares it against an expected truth table held in a parameter.
- It reports the error count, the first failing vector and a pass/fail verdict.
- It replaces hand-written initial-block stimulus for on-board self-test.

Parameters:
- NIN, 3, number of DUT inputs; vector index width; 2**NIN vectors per run.
- EXPECTED, 8'h31, expected y per vector; bit i = expected y for index i, where i = {a,b,c} (a is MSB). Width 2**NIN.
- SETTLE, 1, cycles between driving a vector and sampling y; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
- a  out  1  DUT input, equal to idx[NIN-1].
- b  out  1  DUT input, equal to idx[NIN-2].
- c  out  1  DUT input, equal to idx[NIN-3].
- y  in  1  DUT output under check.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  valid from the done pulse until the next accepted start; 1 = zero mismatches.
- err_count  out  NIN+1  number of mismatches in the current or last run.
- fail_valid  out  1  at least one mismatch has occurred in this run.
- first_fail_idx  out  NIN  index of the first mismatching vector; valid when fail_valid=1.

Behaviour:
- Reset values (asynchronous, reset_n=0): state=IDLE; idx=0, so a=b=c=0; busy=0; done=0; pass=0; err_count=0; fail_valid=0; first_fail_idx=0; settle counter=0.
- All outputs are registered. a, b and c come straight from the idx register, so they are glitch-free.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1 -> SETTLE:
  - idx<=0, cnt<=SETTLE-1.
  - Clear err_count, fail_valid, first_fail_idx and pass.
  - busy<=1.
- SETTLE: if cnt==0 -> CHECK, else cnt<=cnt-1.
- CHECK (one cycle):
  - Sample y and compare against EXPECTED[idx].
  - On mismatch: err_count<=err_count+1. If fail_valid==0, set fail_valid<=1 and first_fail_idx<=idx.
  - If idx==2**NIN-1 -> DONE, busy<=0, done<=1 for one cycle, pass<=(final err_count==0).
  - Otherwise idx<=idx+1, cnt<=SETTLE-1, -> SETTLE.
- Vector timing: each vector occupies SETTLE+1 cycles. The done pulse arrives 2**NIN*(SETTLE+1) cycles after the start-accept edge; default 16 cycles.
- idx does not wrap during a run and holds its last value (2**NIN-1) in DONE.
- err_count never overflows, since its maximum is 2**NIN and it is NIN+1 bits wide.
- The pass computation must include a mismatch detected in the final CHECK cycle.
- start while busy=1 is ignored, with no restart and no effect.
- start in the same cycle as the done pulse: the state is DONE, so it is accepted on the next edge.
- reset_n asserted mid-run: immediate return to reset values; no done pulse.
- The y sample is taken only in CHECK; y in other states is don't-care.

Optional Feature:
- Macro: TV_STOP_ON_ERR_EN.
- Defined:
  - A mismatch in CHECK ends the run immediately: -> DONE, done pulse, pass=0, err_count=1, first_fail_idx=failing index.
  - idx holds the failing vector, so a, b and c keep presenting it for debug.
- Undefined: all 2**NIN vectors always run and every mismatch is counted.

Test Plan:
- Correct DUT (y = ~b&~c | a&~b), default params, start pulse -> a,b,c step 000..111 each held 2 cycles; done pulse 16 cycles after accept; pass=1, err_count=0, fail_valid=0.
- Model y stuck-at-0 -> done, pass=0, err_count=3, first_fail_idx=0, fail_valid=1.
- SETTLE=3, y delayed by 2 cycles behind abc, correct function -> pass=1; done pulse at 32 cycles after accept.
- start re-pulsed at cycle 5 of a run -> ignored; single done pulse at cycle 16. Then start pulsed in DONE -> new run begins and pass/err_count clear on the accept edge.
- reset_n low for 1 cycle at cycle 7 -> a=b=c=0, busy=0, no done pulse. Subsequent start -> full clean run.
- With TV_STOP_ON_ERR_EN, y inverted -> done pulse after the first vector (2 cycles); err_count=1, first_fail_idx=0, a,b,c hold 000.
